// File: rtl/signed_divider.sv
// Sequential signed 16/8 restoring divider with start/busy/done handshake.
// Optional divide-by-zero short-cut and flag enabled by SIGNED_DIVIDER_DBZ_EN.
module signed_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        ovf,
    output logic        dbz
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [15:0] dvd_q;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [7:0]  rem_r;
    logic [7:0]  dvs_mag;
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        ovf_pend;
    logic [8:0]  trial;
    logic [7:0]  diff;
    logic        fits;

    assign trial = {rem_r, dvd_q[15]};
    assign fits  = trial >= {1'b0, dvs_mag};
    // When the subtraction is taken the result is below |divisor| <= 128, so 8 bits hold it.
    assign diff  = trial[7:0] - dvs_mag;

`ifdef SIGNED_DIVIDER_DBZ_EN
    logic dbz_pend;
`else
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dvd_q     <= '0;
            rem_r     <= '0;
            dvs_mag   <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_pend  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
`ifdef SIGNED_DIVIDER_DBZ_EN
            dbz_pend  <= 1'b0;
            dbz       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cnt      <= '0;
                        rem_r    <= '0;
                        q_neg    <= dividend[15] ^ divisor[7];
                        r_neg    <= dividend[15];
                        ovf_pend <= (dividend == 16'h8000) && (divisor == 8'hff);
                        dvd_q    <= dividend[15] ? (~dividend + 16'd1) : dividend;
                        dvs_mag  <= divisor[7] ? (~divisor + 8'd1) : divisor;
                        state    <= RUN;
`ifdef SIGNED_DIVIDER_DBZ_EN
                        dbz_pend <= (divisor == 8'h00);
                        // Zeroed operands make FIX produce an all-zero result.
                        if (divisor == 8'h00) begin
                            dvd_q    <= '0;
                            q_neg    <= 1'b0;
                            r_neg    <= 1'b0;
                            ovf_pend <= 1'b0;
                            state    <= FIX;
                        end
`endif
                    end
                end
                RUN: begin
                    rem_r <= fits ? diff : trial[7:0];
                    dvd_q <= {dvd_q[14:0], fits};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd15)
                        state <= FIX;
                end
                FIX: begin
                    quotient  <= q_neg ? (~dvd_q + 16'd1) : dvd_q;
                    remainder <= r_neg ? (~rem_r + 8'd1) : rem_r;
                    ovf       <= ovf_pend;
`ifdef SIGNED_DIVIDER_DBZ_EN
                    dbz       <= dbz_pend;
`endif
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_divider.sv
// Directed self-checking bench for signed_divider: arithmetic vectors, latency,
// handshake corner cases, mid-run reset and (when enabled) divide-by-zero.
module tb_signed_divider;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dbz;

    int tests = 0;
    int fails = 0;

    signed_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive operands with start; returns at the negedge following the start edge.
    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
    endtask

    // Called at the negedge after the start edge; checks latency, busy length and results.
    task automatic wait_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                               input logic eovf, input int poke, input bit hold);
        int cycles;
        int busy_cyc;
        cycles   = 0;
        busy_cyc = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cyc++;
            start = hold || (poke != 0 && cycles == poke);
            @(negedge clk);
            cycles++;
        end
        chk({tag, " latency"}, cycles, 17);
        chk({tag, " busy_len"}, busy_cyc, 17);
        chk({tag, " busy@done"}, busy, 0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " ovf"}, ovf, eovf);
        chk({tag, " dbz"}, dbz, 0);
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        chk({tag, " done_drop"}, done, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " quotient"}, quotient, 0);
        chk({tag, " remainder"}, remainder, 0);
        chk({tag, " ovf"}, ovf, 0);
        chk({tag, " dbz"}, dbz, 0);
    endtask

    initial begin
        bit seen_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        launch(16'h000a, 8'h02); wait_result("basic", 16'h0005, 8'h00, 0, 0, 0); post_idle("basic");
        launch(16'hffe4, 8'h04); wait_result("neg_dvd", 16'hfff9, 8'h00, 0, 0, 0);
        launch(16'h3f01, 8'h7f); wait_result("max_pos", 16'h007f, 8'h00, 0, 0, 0);
        launch(16'h4000, 8'h80); wait_result("min_dvs", 16'hff80, 8'h00, 0, 0, 0);
        launch(16'h0046, 8'hf6); wait_result("neg_dvs", 16'hfff9, 8'h00, 0, 0, 0);
        launch(16'hfff9, 8'h02); wait_result("trunc_n", 16'hfffd, 8'hff, 0, 0, 0);
        launch(16'h0007, 8'hfe); wait_result("trunc_p", 16'hfffd, 8'h01, 0, 0, 0);
        launch(16'h8000, 8'h01); wait_result("min_by1", 16'h8000, 8'h00, 0, 0, 0);
        launch(16'h8000, 8'h80); wait_result("min_min", 16'h0100, 8'h00, 0, 0, 0);
        launch(16'h8000, 8'hff); wait_result("ovf", 16'h8000, 8'h00, 1, 0, 0);
        launch(16'h000c, 8'h04); wait_result("after_ovf", 16'h0003, 8'h00, 0, 0, 0);

        // Second start mid-run must be ignored.
        launch(16'h7fff, 8'h80); wait_result("poke", 16'hff01, 8'h7f, 0, 5, 0);
        post_idle("poke");
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("poke no_2nd_done", seen_done, 0);
        chk("poke held_q", quotient, 16'hff01);
        chk("poke held_r", remainder, 8'h7f);

        // Start held through done: next op captured on the edge after done.
        launch(16'h0046, 8'hf6); wait_result("hold1", 16'hfff9, 8'h00, 0, 0, 1);
        dividend = 16'h000a;
        divisor  = 8'h02;
        @(negedge clk);
        chk("hold restart done", done, 0);
        chk("hold restart busy", busy, 1);
        wait_result("hold2", 16'h0005, 8'h00, 0, 0, 0);
        post_idle("hold2");

        // Asynchronous reset mid-run aborts without a done pulse.
        launch(16'h3f01, 8'h7f);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst pre busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("rst no_done", seen_done, 0);
        launch(16'h000a, 8'h02); wait_result("after_rst", 16'h0005, 8'h00, 0, 0, 0);

`ifdef SIGNED_DIVIDER_DBZ_EN
        launch(16'h0064, 8'h00);
        start = 1'b0;
        @(negedge clk);
        chk("dbz done", done, 1);
        chk("dbz flag", dbz, 1);
        chk("dbz quotient", quotient, 0);
        chk("dbz remainder", remainder, 0);
        chk("dbz ovf", ovf, 0);
        post_idle("dbz");
        launch(16'h000c, 8'h04); wait_result("after_dbz", 16'h0003, 8'h00, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
